// File: rtl/cv32e40p_tmr_scrubber.sv
// Triple-replicated register with write port, fault injection and a periodic
// scrub engine that repairs single-copy faults and reports/counts errors.
module cv32e40p_tmr_scrubber #(
    parameter int unsigned     NBIT         = 32,
    parameter int unsigned     SCRUB_PERIOD = 16,
    parameter int unsigned     CNT_W        = 8,
    parameter logic [NBIT-1:0] RESET_VAL    = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [NBIT-1:0]  wr_data_i,
    input  logic             scrub_en_i,
    input  logic             inj_valid_i,
    input  logic [1:0]       inj_sel_i,
    input  logic [NBIT-1:0]  inj_mask_i,
    output logic [NBIT-1:0]  data1_o,
    output logic [NBIT-1:0]  data2_o,
    output logic [NBIT-1:0]  data3_o,
    output logic             err_single_o,
    output logic             err_multi_o,
    output logic             multi_sticky_o,
    output logic [1:0]       faulty_copy_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int unsigned PW = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
    localparam logic [PW-1:0] PER_LAST = PW'(SCRUB_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        REPAIR
    } state_e;

    state_e            state_q, state_d;
    logic [NBIT-1:0]   c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
    logic [PW-1:0]     per_q, per_d;
    logic              pend_q, pend_d;
    logic              multi_q, multi_d;
    logic              es_q, es_d, em_q, em_d;
    logic              sticky_q, sticky_d;
    logic [1:0]        fc_q, fc_d;
    logic [CNT_W-1:0]  ec_q, ec_d;
    logic              wrap, start;
    logic              eq12, eq13, eq23;
    logic [NBIT-1:0]   maj;

    assign eq12 = (c1_q == c2_q);
    assign eq13 = (c1_q == c3_q);
    assign eq23 = (c2_q == c3_q);
    assign maj  = (c1_q & c2_q) | (c1_q & c3_q) | (c2_q & c3_q);

    // Next-state: writes/injection/scrub start in IDLE, compare in CHECK, fix in REPAIR.
    always_comb begin
        state_d  = state_q;
        c1_d     = c1_q;
        c2_d     = c2_q;
        c3_d     = c3_q;
        per_d    = per_q;
        pend_d   = pend_q;
        multi_d  = multi_q;
        es_d     = 1'b0;
        em_d     = 1'b0;
        sticky_d = sticky_q;
        fc_d     = fc_q;
        ec_d     = ec_q;
        wrap     = 1'b0;
        start    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (scrub_en_i) begin
                    if (per_q == PER_LAST) begin
                        per_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        per_d = per_q + PW'(1);
                    end
                end
                if (wr_valid_i) begin
                    c1_d = wr_data_i;
                    c2_d = wr_data_i;
                    c3_d = wr_data_i;
                end else if (inj_valid_i) begin
                    case (inj_sel_i)
                        2'd1:    c1_d = c1_q ^ inj_mask_i;
                        2'd2:    c2_d = c2_q ^ inj_mask_i;
                        2'd3:    c3_d = c3_q ^ inj_mask_i;
                        default: ;
                    endcase
                end else if (pend_q) begin
                    start   = 1'b1;
                    state_d = CHECK;
                end
                pend_d = (pend_q & ~start) | wrap;
            end
            CHECK: begin
                if (eq12 && eq13) begin
                    state_d = IDLE;
                end else begin
                    state_d = REPAIR;
                    ec_d    = (&ec_q) ? ec_q : ec_q + CNT_W'(1);
                    if (!eq12 && !eq13 && !eq23) begin
                        multi_d  = 1'b1;
                        em_d     = 1'b1;
                        sticky_d = 1'b1;
                    end else begin
                        multi_d = 1'b0;
                        es_d    = 1'b1;
                        fc_d    = eq23 ? 2'd1 : (eq13 ? 2'd2 : 2'd3);
                    end
                end
            end
            REPAIR: begin
                state_d = IDLE;
                if (multi_q) begin
                    c2_d = c1_q;
                    c3_d = c1_q;
                end else begin
                    c1_d = maj;
                    c2_d = maj;
                    c3_d = maj;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and copy registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            c1_q     <= RESET_VAL;
            c2_q     <= RESET_VAL;
            c3_q     <= RESET_VAL;
            per_q    <= '0;
            pend_q   <= 1'b0;
            multi_q  <= 1'b0;
            es_q     <= 1'b0;
            em_q     <= 1'b0;
            sticky_q <= 1'b0;
            fc_q     <= 2'd0;
            ec_q     <= '0;
        end else begin
            state_q  <= state_d;
            c1_q     <= c1_d;
            c2_q     <= c2_d;
            c3_q     <= c3_d;
            per_q    <= per_d;
            pend_q   <= pend_d;
            multi_q  <= multi_d;
            es_q     <= es_d;
            em_q     <= em_d;
            sticky_q <= sticky_d;
            fc_q     <= fc_d;
            ec_q     <= ec_d;
        end
    end

    assign wr_ready_o     = (state_q == IDLE);
    assign data1_o        = c1_q;
    assign data2_o        = c2_q;
    assign data3_o        = c3_q;
    assign err_single_o   = es_q;
    assign err_multi_o    = em_q;
    assign multi_sticky_o = sticky_q;
    assign faulty_copy_o  = fc_q;
    assign err_cnt_o      = ec_q;

endmodule

// File: tb/tb_cv32e40p_tmr_scrubber.sv
// Bench for cv32e40p_tmr_scrubber: directed vectors, a behavioural model
// compared every cycle, and literal expectations at key points.
module tb_cv32e40p_tmr_scrubber;

    localparam int NBIT = 32;
    localparam int P    = 4;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wr_valid;
    logic            wr_ready;
    logic [NBIT-1:0] wr_data;
    logic            scrub_en;
    logic            inj_valid;
    logic [1:0]      inj_sel;
    logic [NBIT-1:0] inj_mask;
    logic [NBIT-1:0] d1, d2, d3;
    logic            es, em, sticky;
    logic [1:0]      fc;
    logic [CW-1:0]   ec;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cv32e40p_tmr_scrubber #(
        .NBIT         (NBIT),
        .SCRUB_PERIOD (P),
        .CNT_W        (CW),
        .RESET_VAL    ('0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_valid_i     (wr_valid),
        .wr_ready_o     (wr_ready),
        .wr_data_i      (wr_data),
        .scrub_en_i     (scrub_en),
        .inj_valid_i    (inj_valid),
        .inj_sel_i      (inj_sel),
        .inj_mask_i     (inj_mask),
        .data1_o        (d1),
        .data2_o        (d2),
        .data3_o        (d3),
        .err_single_o   (es),
        .err_multi_o    (em),
        .multi_sticky_o (sticky),
        .faulty_copy_o  (fc),
        .err_cnt_o      (ec)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 comparing, 2 repairing.
    logic [31:0] mc [1:3];
    int  m_per, m_phase, m_k, m_fc, m_ec;
    int  agree [1:3];
    int  n_alone, n_all;
    bit  m_pend, m_multi, m_es, m_em, m_st, m_ok = 0;
    bit  go, wrap;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i <= 3; i++) mc[i] = '0;
            m_per = 0; m_phase = 0; m_k = 0; m_fc = 0; m_ec = 0;
            m_pend = 0; m_multi = 0; m_es = 0; m_em = 0; m_st = 0;
            m_ok = 1;
        end else begin
            m_es = 0;
            m_em = 0;
            if (m_phase == 0) begin
                go = 0;
                wrap = 0;
                if (scrub_en) begin
                    m_per = m_per + 1;
                    if (m_per == P) begin
                        m_per = 0;
                        wrap = 1;
                    end
                end
                if (wr_valid) begin
                    for (int i = 1; i <= 3; i++) mc[i] = wr_data;
                end else if (inj_valid) begin
                    if (inj_sel != 0) mc[inj_sel] = mc[inj_sel] ^ inj_mask;
                end else if (m_pend) begin
                    go = 1;
                end
                m_pend = (m_pend && !go) || wrap;
                if (go) m_phase = 1;
            end else if (m_phase == 1) begin
                n_alone = 0;
                n_all = 0;
                for (int i = 1; i <= 3; i++) begin
                    agree[i] = 0;
                    for (int j = 1; j <= 3; j++)
                        if (j != i && mc[j] == mc[i]) agree[i]++;
                    if (agree[i] == 0) begin
                        n_alone++;
                        m_k = i;
                    end
                    if (agree[i] == 2) n_all++;
                end
                if (n_all == 3) begin
                    m_phase = 0;
                end else begin
                    m_phase = 2;
                    m_ec = (m_ec < CMAX) ? m_ec + 1 : CMAX;
                    if (n_alone == 3) begin
                        m_multi = 1; m_em = 1; m_st = 1;
                    end else begin
                        m_multi = 0; m_es = 1; m_fc = m_k;
                    end
                end
            end else begin
                if (m_multi) begin
                    mc[2] = mc[1];
                    mc[3] = mc[1];
                end else begin
                    mc[m_k] = mc[(m_k % 3) + 1];
                end
                m_phase = 0;
            end
        end
    end

    // Compare DUT against the model on every falling edge after reset.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_data1", d1, mc[1]);
            chk("m_data2", d2, mc[2]);
            chk("m_data3", d3, mc[3]);
            chk("m_ready", 32'(wr_ready), 32'(m_phase == 0));
            chk("m_single", 32'(es), 32'(m_es));
            chk("m_multi", 32'(em), 32'(m_em));
            chk("m_sticky", 32'(sticky), 32'(m_st));
            chk("m_faulty", 32'(fc), 32'(m_fc));
            chk("m_cnt", 32'(ec), 32'(m_ec));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // what: 0 single pulse, 1 multi pulse, 2 ready low
    task automatic wait_for(input int what, input string nm);
        int n = 0;
        bit hit = 0;
        while (n < 40 && !hit) begin
            hit = (what == 0) ? es : (what == 1) ? em : !wr_ready;
            if (!hit) begin
                @(negedge clk);
                n++;
            end
        end
        if (!hit) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles", nm, n);
        end
    endtask

    initial begin
        rst_n = 0; wr_valid = 0; wr_data = '0; scrub_en = 0;
        inj_valid = 0; inj_sel = 0; inj_mask = '0;
        cyc(2);
        chk("t1_data1", d1, 32'h0);
        chk("t1_data3", d3, 32'h0);
        chk("t1_ready", 32'(wr_ready), 32'h1);
        chk("t1_cnt", 32'(ec), 32'h0);
        chk("t1_faulty", 32'(fc), 32'h0);
        rst_n = 1;

        wr_valid = 1; wr_data = 32'hDEADBEEF;
        cyc(1);
        wr_valid = 0;
        chk("t2_data1", d1, 32'hDEADBEEF);
        chk("t2_data2", d2, 32'hDEADBEEF);
        chk("t2_data3", d3, 32'hDEADBEEF);
        chk("t2_single", 32'(es), 32'h0);

        inj_valid = 1; inj_sel = 2; inj_mask = 32'h1;
        cyc(1);
        inj_valid = 0;
        chk("t3_inj", d2, 32'hDEADBEEE);
        scrub_en = 1;
        wait_for(0, "t3_single_wait");
        chk("t3_faulty", 32'(fc), 32'h2);
        chk("t3_cnt", 32'(ec), 32'h1);
        chk("t3_ready", 32'(wr_ready), 32'h0);
        scrub_en = 0;
        cyc(1);
        chk("t3_fixed", d2, 32'hDEADBEEF);
        chk("t3_ready2", 32'(wr_ready), 32'h1);

        inj_valid = 1; inj_sel = 2; inj_mask = 32'h1;
        cyc(1);
        inj_sel = 3; inj_mask = 32'h2;
        cyc(1);
        inj_valid = 0;
        scrub_en = 1;
        wait_for(1, "t4_multi_wait");
        chk("t4_sticky", 32'(sticky), 32'h1);
        chk("t4_cnt", 32'(ec), 32'h2);
        scrub_en = 0;
        cyc(1);
        chk("t4_data2", d2, 32'hDEADBEEF);
        chk("t4_data3", d3, 32'hDEADBEEF);

        rst_n = 0;
        cyc(1);
        rst_n = 1;
        chk("t5_sticky_clr", 32'(sticky), 32'h0);
        scrub_en = 1;
        cyc(4);
        scrub_en = 0;
        wr_valid = 1; wr_data = 32'h12345678;
        cyc(1);
        wr_valid = 0;
        chk("t5_write_won", d1, 32'h12345678);
        chk("t5_ready_w", 32'(wr_ready), 32'h1);
        cyc(1);
        chk("t5_check_ready", 32'(wr_ready), 32'h0);
        wr_valid = 1; wr_data = 32'hA5A5A5A5;
        cyc(1);
        chk("t5_held_ready", 32'(wr_ready), 32'h1);
        chk("t5_held_data", d1, 32'h12345678);
        cyc(1);
        wr_valid = 0;
        chk("t5_accepted", d3, 32'hA5A5A5A5);
        wr_valid = 1; wr_data = 32'h0F0F0F0F;
        inj_valid = 1; inj_sel = 1; inj_mask = 32'hFFFF;
        cyc(1);
        wr_valid = 0; inj_valid = 0;
        chk("t5_inj_drop", d1, 32'h0F0F0F0F);

        for (int i = 0; i < 5; i++) begin
            inj_valid = 1; inj_sel = 2'((i % 3) + 1); inj_mask = 32'(1) << i;
            cyc(1);
            inj_valid = 0;
            scrub_en = 1;
            wait_for(0, "t6_single_wait");
            chk("t6_cnt", 32'(ec), (i + 1 < CMAX) ? i + 1 : CMAX);
            chk("t6_faulty", 32'(fc), (i % 3) + 1);
            scrub_en = 0;
            cyc(1);
        end

        inj_valid = 1; inj_sel = 1; inj_mask = 32'h80;
        cyc(1);
        inj_valid = 0;
        scrub_en = 1;
        wait_for(2, "t6_check_wait");
        rst_n = 0;
        scrub_en = 0;
        cyc(1);
        chk("t6_rst_single", 32'(es), 32'h0);
        chk("t6_rst_cnt", 32'(ec), 32'h0);
        chk("t6_rst_data1", d1, 32'h0);
        chk("t6_rst_faulty", 32'(fc), 32'h0);
        rst_n = 1;
        cyc(3);
        chk("t6_no_pulse", 32'(es), 32'h0);
        chk("t6_ready_end", 32'(wr_ready), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
